// File: rtl/button_counter.sv
// Up/down pushbutton counter: each button is synchronized and debounced, then drives
// a press/auto-repeat FSM whose step pulses move an 8-bit wrap-around count on leds.
module button_counter #(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] leds
);
    localparam int DB   = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int HOLD = CLK_FREQ / 2;
    localparam int RPT  = CLK_FREQ / 10;
    localparam int DW   = (DB > 1) ? $clog2(DB) : 1;
    localparam int TW   = (HOLD > 1) ? $clog2(HOLD) : 1;

    // IDLE: waiting for press | HELD: waiting out auto-repeat delay | REPEAT: repeating
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [1:0]    btn_raw;
    logic [1:0]    sync_q  [2];
    logic [1:0]    db_q;
    logic [DW-1:0] dcnt_q  [2];
    logic [TW-1:0] tcnt_q  [2];
    state_t        state_q [2];
    logic [1:0]    step_q;
    logic [7:0]    leds_q;
    logic [7:0]    leds_d;

    assign btn_raw = {btn_down, btn_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i]  <= '0;
                dcnt_q[i]  <= '0;
                tcnt_q[i]  <= '0;
                state_q[i] <= ST_IDLE;
            end
            db_q   <= '0;
            step_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][0], btn_raw[i]};

                if (sync_q[i][1] == db_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DW'(DB - 1)) begin
                    db_q[i]   <= sync_q[i][1];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + 1'b1;
                end

                // Release is checked before timer expiry so a coincident release suppresses the pulse.
                step_q[i] <= 1'b0;
                case (state_q[i])
                    ST_IDLE: begin
                        if (db_q[i]) begin
                            step_q[i]  <= 1'b1;
                            tcnt_q[i]  <= '0;
                            state_q[i] <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (!db_q[i]) begin
                            state_q[i] <= ST_IDLE;
                        end else if (tcnt_q[i] == TW'(HOLD - 1)) begin
                            step_q[i]  <= 1'b1;
                            tcnt_q[i]  <= '0;
                            state_q[i] <= ST_REPEAT;
                        end else begin
                            tcnt_q[i] <= tcnt_q[i] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!db_q[i]) begin
                            state_q[i] <= ST_IDLE;
                        end else if (tcnt_q[i] == TW'(RPT - 1)) begin
                            step_q[i] <= 1'b1;
                            tcnt_q[i] <= '0;
                        end else begin
                            tcnt_q[i] <= tcnt_q[i] + 1'b1;
                        end
                    end
                    default: state_q[i] <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        leds_d = leds_q;
        case (step_q)
            2'b01:   leds_d = leds_q + 8'd1;
            2'b10:   leds_d = leds_q - 8'd1;
            default: leds_d = leds_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) leds_q <= 8'h00;
        else        leds_q <= leds_d;
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter: directed scenarios with literal expectations plus a long
// randomized run checked every cycle against a press/hold-time reference model.
module tb_button_counter;
    localparam int CLK_FREQ    = 1000;
    localparam int DEBOUNCE_MS = 4;
    localparam int DB   = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int HOLD = CLK_FREQ / 2;
    localparam int RPT  = CLK_FREQ / 10;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic [7:0] leds;

    int checks   = 0;
    int failures = 0;
    int chg[$];

    button_counter #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .leds     (leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: sync delay, then db flips after DB consecutive differing samples;
    // steps follow from how long db has been continuously high.
    bit   [1:0] m_s1   = '0;
    bit   [1:0] m_s2   = '0;
    bit   [1:0] m_db   = '0;
    bit   [1:0] m_step = '0;
    int         m_mc   [2] = '{0, 0};
    int         m_run  [2] = '{0, 0};
    logic [7:0] m_leds = 8'h00;

    always @(posedge clk) begin
        bit raw;
        bit nstep;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_step = '0;
            m_mc = '{0, 0}; m_run = '{0, 0};
            m_leds = 8'h00;
        end else begin
            m_leds = m_leds + 8'(m_step[0]) - 8'(m_step[1]);
            for (int b = 0; b < 2; b++) begin
                raw   = (b == 0) ? btn_up : btn_down;
                nstep = m_db[b] && (m_run[b] == 1 || m_run[b] == HOLD + 1 ||
                        (m_run[b] > HOLD + 1 && (m_run[b] - HOLD - 1) % RPT == 0));
                if (m_s2[b] != m_db[b]) begin
                    m_mc[b]++;
                    if (m_mc[b] == DB) begin
                        m_db[b] = m_s2[b];
                        m_mc[b] = 0;
                    end
                end else begin
                    m_mc[b] = 0;
                end
                m_s2[b]  = m_s1[b];
                m_s1[b]  = raw;
                m_run[b] = m_db[b] ? m_run[b] + 1 : 0;
                m_step[b] = nstep;
            end
        end
        #1;
        checks++;
        if (leds !== m_leds) begin
            failures++;
            $display("FAIL model_leds t=%0t actual=%02h expected=%02h", $time, leds, m_leds);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_leds", int'(leds), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode 0: steady press for len cycles; mode 1: toggle every 2 cycles for len cycles.
    task automatic watch(input int n, input int up_len, input int dn_len, input int mode);
        logic [7:0] prev;
        chg.delete();
        prev = leds;
        for (int k = 0; k < n; k++) begin
            if (mode == 0) begin
                btn_up   = (k < up_len);
                btn_down = (k < dn_len);
            end else begin
                btn_up   = (k < up_len) && ((k / 2) % 2 == 0);
                btn_down = 1'b0;
            end
            @(posedge clk);
            #2;
            if (leds !== prev) begin
                chg.push_back(k);
                prev = leds;
            end
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    initial begin
        int  rem [2];
        bit  lvl [2];
        int  r;
        int  rst_left;
        int  exp_edges [4];

        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        do_reset();

        // Single clean press: one increment, 7 edges after the first sampling edge.
        watch(40, 20, 0, 0);
        chk("press_nchg", chg.size(), 1);
        if (chg.size() > 0) chk("press_edge", chg[0], 7);
        chk("press_leds", int'(leds), 1);

        // Bounce shorter than the window never registers.
        do_reset();
        watch(50, 30, 0, 1);
        chk("bounce_nchg", chg.size(), 0);
        chk("bounce_leds", int'(leds), 0);

        // Long hold: first step, auto-repeat delay, then repeat period.
        do_reset();
        watch(750, 750, 0, 0);
        exp_edges = '{7, 507, 607, 707};
        chk("hold_nchg", chg.size(), 4);
        for (int i = 0; i < 4 && i < chg.size(); i++) chk("hold_edge", chg[i], exp_edges[i]);
        chk("hold_leds", int'(leds), 4);
        watch(10, 0, 0, 0);

        // Wrap-around in both directions.
        do_reset();
        watch(40, 0, 20, 0);
        chk("wrap_down", int'(leds), 255);
        watch(40, 20, 0, 0);
        chk("wrap_up", int'(leds), 0);

        // Simultaneous presses cancel.
        do_reset();
        watch(40, 20, 20, 0);
        chk("both_nchg", chg.size(), 0);
        chk("both_leds", int'(leds), 0);

        // Reset in the middle of a hold, button kept held through and after reset.
        do_reset();
        btn_up = 1'b1;
        repeat (150) @(posedge clk);
        #2;
        chk("prerst_leds", int'(leds), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_leds", int'(leds), 0);
        repeat (3) @(posedge clk);
        #2;
        chk("midrst_leds", int'(leds), 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch(20, 20, 0, 0);
        chk("postrst_nchg", chg.size(), 1);
        if (chg.size() > 0) chk("postrst_edge", chg[0], 7);
        chk("postrst_leds", int'(leds), 1);

        // Randomized run: mixed glitches, short/medium presses, long holds, random resets.
        do_reset();
        rem      = '{0, 0};
        lvl      = '{1'b0, 1'b0};
        rst_left = 0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if (!rst_n) begin
                if (rst_left == 0) rst_n = 1'b1;
                else rst_left--;
            end else if ($urandom_range(0, 2999) == 0) begin
                rst_n    = 1'b0;
                rst_left = int'($urandom_range(0, 2));
            end
            for (int b = 0; b < 2; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = ~lvl[b];
                    r = int'($urandom_range(0, 9));
                    if (r < 4)      rem[b] = int'($urandom_range(1, 6));
                    else if (r < 9) rem[b] = int'($urandom_range(5, 40));
                    else            rem[b] = int'($urandom_range(400, 900));
                end
                rem[b]--;
            end
            btn_up   = lvl[0];
            btn_down = lvl[1];
        end
        @(negedge clk);
        rst_n    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (20) @(posedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_counter.md
BUTTON_COUNTER -- requirements
Module: button_counter

Interface
REQ-001 Parameter CLK_FREQ, default 25_000_000, clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 10, debounce window in ms; DB = CLK_FREQ/1000*DEBOUNCE_MS cycles, DB >= 1.
REQ-003 Derived constants SHALL be HOLD = CLK_FREQ/2 cycles (auto-repeat delay) and RPT = CLK_FREQ/10 cycles (auto-repeat period).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 btn_up  input  1  raw pushbutton, active-high, asynchronous to clk, may bounce.
REQ-007 btn_down  input  1  raw pushbutton, active-high, asynchronous to clk, may bounce.
REQ-008 leds  output  8  current count, driven directly from a register.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each button SHALL have an independent debouncer: debounced level db, counter dcnt, width sufficient for DB.
REQ-011 Debouncer: sync == db -> dcnt <= 0; sync != db and dcnt < DB-1 -> dcnt <= dcnt+1; sync != db and dcnt == DB-1 -> db <= sync, dcnt <= 0.
REQ-012 Any glitch shorter than DB cycles (post-sync) SHALL leave db unchanged and restart dcnt.
REQ-013 Each button SHALL have a 3-state FSM: IDLE, HELD, REPEAT, with a timer tcnt.
REQ-014 IDLE: db rising (0->1) -> emit one-cycle step pulse, tcnt <= 0, go HELD.
REQ-015 HELD: db == 0 -> IDLE; tcnt == HOLD-1 -> emit step pulse, tcnt <= 0, go REPEAT; else tcnt+1.
REQ-016 REPEAT: db == 0 -> IDLE; tcnt == RPT-1 -> emit step pulse, tcnt <= 0; else tcnt+1.
REQ-017 Release (db 1->0) SHALL emit no pulse; a release in the same cycle a timer expires SHALL suppress that pulse.
REQ-018 Count update on step pulses: up only -> leds+1; down only -> leds-1; both same cycle -> unchanged; none -> unchanged.
REQ-019 Arithmetic SHALL be 8-bit modulo: 8'hFF +1 -> 8'h00; 8'h00 -1 -> 8'hFF.
REQ-020 Latency: leds SHALL change exactly DB+3 rising edges after the first edge sampling a clean new raw press (2 sync + DB debounce + 1 count register).
REQ-021 Both buttons held SHALL be handled independently; coinciding pulses follow REQ-018.
REQ-022 No combinational path from btn_up/btn_down to leds.

Reset
REQ-023 rst_n low SHALL immediately (asynchronously) force leds = 8'h00, synchronizer flops = 0, db = 0, dcnt = 0, tcnt = 0, FSMs = IDLE.
REQ-024 Reset asserted mid-press or mid-repeat SHALL discard all progress; a button still held at rst_n release SHALL count once after DB+3 edges (db rises from 0).
REQ-025 rst_n deassertion is synchronous to clk externally; the block need not resynchronize it.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=4 -> DB=4, HOLD=500, RPT=100)
REQ-026 Clean btn_up press held 20 cycles then released -> leds 0x00 -> 0x01 exactly 7 edges after press; no further change.
REQ-027 btn_up toggling every 2 cycles for 30 cycles then low -> leds remains 0x00.
REQ-028 btn_up held 750 cycles from reset -> leds increments at edge 7, 507, 607, 707; final 0x04.
REQ-029 leds = 0x00, single clean btn_down press -> 0xFF; from 0xFF, single btn_up press -> 0x00.
REQ-030 btn_up and btn_down pressed on the same edge, held 20 cycles -> leds unchanged.
REQ-031 btn_up held 300 cycles, rst_n pulsed low for 3 cycles mid-hold, button kept held -> leds 0x00 during reset, 0x01 exactly 7 edges after rst_n rises.
